// File: rtl/dm_unit_if.sv
// Bus between the datapath and the data-memory stage.
// master: driven by the datapath (pc, addr, wdata, mem_write, mem_read, mem_data_type),
//         receives rdata and the error capture (align_err, err_pc, err_addr).
// slave:  the data-memory stage, mirror image of master.
interface dm_unit_if;
   logic [31:0] pc;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  mem_data_type;
   logic [31:0] rdata;
   logic        align_err;
   logic [31:0] err_pc;
   logic [31:0] err_addr;

   modport master (
      output pc, addr, wdata, mem_write, mem_read, mem_data_type,
      input  rdata, align_err, err_pc, err_addr
   );

   modport slave (
      input  pc, addr, wdata, mem_write, mem_read, mem_data_type,
      output rdata, align_err, err_pc, err_addr
   );
endinterface

// File: rtl/dm_unit.sv
// Data-memory stage of the single-cycle MIPS datapath.
// Word/half/byte loads (sign-extended) and stores (lane merge), combinational read,
// synchronous store. Misaligned or reserved-type accesses are suppressed and the first
// one is captured in err_pc/err_addr behind a sticky align_err flag.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-low; clears the array and the error capture
//   bus   - dm_unit_if.slave: pc, addr, wdata, mem_write, mem_read, mem_data_type in;
//           rdata, align_err, err_pc, err_addr out
// Optional macro DM_WRITE_LOG_EN: when defined, every committed store prints
//   "@<pc>: *<word byte address> <= <merged word>".
module dm_unit #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic      clk,
   input logic      reset,
   dm_unit_if.slave bus
);
   localparam int unsigned IW = $clog2(DEPTH_WORDS);

   localparam logic [2:0] DtWord = 3'b000;
   localparam logic [2:0] DtHalf = 3'b001;
   localparam logic [2:0] DtByte = 3'b010;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [31:0]   off;
   logic [IW-1:0] idx;
   logic [31:0]   cur_word;
   logic          illegal;
   logic          mem_we_d;
   logic [31:0]   mem_wdata_d;
   logic          align_err_d, align_err_q;
   logic [31:0]   err_pc_d, err_pc_q;
   logic [31:0]   err_addr_d, err_addr_q;
   logic          unused_off;

   // Upper bits are dropped so out-of-range addresses wrap modulo DEPTH_WORDS.
   assign off        = bus.addr - BASE_ADDR;
   assign idx        = off[IW+1:2];
   assign cur_word   = mem_q[idx];
   assign unused_off = ^{off[31:IW+2], off[1:0]};

   // Load path, independent of mem_read.
   always_comb begin
      logic [15:0] h;
      logic [7:0]  b;
      h         = bus.addr[1] ? cur_word[31:16] : cur_word[15:0];
      b         = cur_word[8*bus.addr[1:0] +: 8];
      bus.rdata = '0;
      case (bus.mem_data_type)
         DtWord:  bus.rdata = cur_word;
         DtHalf:  bus.rdata = {{16{h[15]}}, h};
         DtByte:  bus.rdata = {{24{b[7]}}, b};
         default: bus.rdata = '0;
      endcase
   end

   // Legality check and store lane merge.
   always_comb begin
      logic bad;
      bad         = 1'b0;
      mem_wdata_d = cur_word;
      case (bus.mem_data_type)
         DtWord: begin
            bad         = (bus.addr[1:0] != 2'b00);
            mem_wdata_d = bus.wdata;
         end
         DtHalf: begin
            bad = bus.addr[0];
            if (bus.addr[1]) mem_wdata_d[31:16] = bus.wdata[15:0];
            else             mem_wdata_d[15:0]  = bus.wdata[15:0];
         end
         DtByte: begin
            mem_wdata_d[8*bus.addr[1:0] +: 8] = bus.wdata[7:0];
         end
         default: bad = 1'b1;
      endcase
      // Qualify by access so an idle bus with X on mem_data_type causes nothing.
      illegal  = (bus.mem_write | bus.mem_read) & bad;
      mem_we_d = bus.mem_write & ~illegal;
   end

   // First-fault capture; the flag is sticky until reset.
   always_comb begin
      align_err_d = align_err_q;
      err_pc_d    = err_pc_q;
      err_addr_d  = err_addr_q;
      if (illegal) begin
         align_err_d = 1'b1;
         if (!align_err_q) begin
            err_pc_d   = bus.pc;
            err_addr_d = bus.addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
      end else if (mem_we_d) begin
         mem_q[idx] <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         align_err_q <= 1'b0;
         err_pc_q    <= '0;
         err_addr_q  <= '0;
      end else begin
         align_err_q <= align_err_d;
         err_pc_q    <= err_pc_d;
         err_addr_q  <= err_addr_d;
      end
   end

`ifdef DM_WRITE_LOG_EN
   always_ff @(posedge clk) begin
      if (reset && mem_we_d) begin
         $display("@%h: *%h <= %h", bus.pc, BASE_ADDR + 32'({idx, 2'b00}), mem_wdata_d);
      end
   end
`else
`endif

   assign bus.align_err = align_err_q;
   assign bus.err_pc    = err_pc_q;
   assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_dm_unit.sv
// Directed self-checking bench for dm_unit.
module tb_dm_unit;
   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   dm_unit_if bus ();

   dm_unit #(
      .DEPTH_WORDS(1024),
      .BASE_ADDR  (32'h0000_0000)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.mem_write     = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_data_type = 3'b000;
   endtask

   task automatic store(input logic [31:0] pc, input logic [31:0] a, input logic [2:0] dt,
                        input logic [31:0] d);
      bus.pc            = pc;
      bus.addr          = a;
      bus.wdata         = d;
      bus.mem_data_type = dt;
      bus.mem_write     = 1'b1;
      bus.mem_read      = 1'b0;
      step();
      idle();
   endtask

   task automatic load(input string tag, input logic [31:0] a, input logic [2:0] dt,
                       input logic [31:0] exp);
      bus.addr          = a;
      bus.mem_data_type = dt;
      bus.mem_read      = 1'b1;
      bus.mem_write     = 1'b0;
      #1;
      check_eq(tag, bus.rdata, exp);
      idle();
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset   = 1'b0;
      bus.pc  = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      check_eq("rst_align_err", {31'd0, bus.align_err}, 32'd0);
      check_eq("rst_err_pc", bus.err_pc, 32'd0);
      check_eq("rst_err_addr", bus.err_addr, 32'd0);
      load("rst_word_10", 32'h10, 3'b000, 32'h0);

      // Word, byte and half lanes.
      store(32'h3000, 32'h10, 3'b000, 32'h1234_5678);
      load("word_10", 32'h10, 3'b000, 32'h1234_5678);
      store(32'h3000, 32'h13, 3'b010, 32'hCCCC_CCAB);
      load("byte_merge", 32'h10, 3'b000, 32'hAB34_5678);
      load("lb_13", 32'h13, 3'b010, 32'hFFFF_FFAB);
      load("lb_10", 32'h10, 3'b010, 32'h0000_0078);
      load("lb_11", 32'h11, 3'b010, 32'h0000_0056);
      store(32'h3004, 32'h12, 3'b001, 32'h7777_8001);
      load("half_merge", 32'h10, 3'b000, 32'h8001_5678);
      load("lh_12", 32'h12, 3'b001, 32'hFFFF_8001);
      load("lh_10", 32'h10, 3'b001, 32'h0000_5678);
      load("lb_12", 32'h12, 3'b010, 32'h0000_0001);
      load("lb_13b", 32'h13, 3'b010, 32'hFFFF_FF80);

      // Reserved type reads zero; without an access it is not an error.
      bus.addr = 32'h10;
      bus.mem_data_type = 3'b011;
      #1;
      check_eq("rsv_rdata", bus.rdata, 32'h0);
      step();
      check_eq("rsv_noerr", {31'd0, bus.align_err}, 32'd0);
      idle();

      // Misaligned store is dropped and captured.
      store(32'h3010, 32'h22, 3'b000, 32'hFFFF_FFFF);
      check_eq("mis_flag", {31'd0, bus.align_err}, 32'd1);
      check_eq("mis_pc", bus.err_pc, 32'h3010);
      check_eq("mis_addr", bus.err_addr, 32'h22);
      load("mis_mem20", 32'h20, 3'b000, 32'h0);

      // Later faults leave the capture untouched.
      bus.pc = 32'h3014;
      bus.addr = 32'h25;
      bus.mem_data_type = 3'b001;
      bus.mem_read = 1'b1;
      step();
      idle();
      check_eq("mis2_flag", {31'd0, bus.align_err}, 32'd1);
      check_eq("mis2_pc", bus.err_pc, 32'h3010);
      check_eq("mis2_addr", bus.err_addr, 32'h22);
      store(32'h3018, 32'h11, 3'b001, 32'h0000_0000);
      load("mis_half_drop", 32'h10, 3'b000, 32'h8001_5678);

      // Address wrap.
      store(32'h3020, 32'h1000, 3'b000, 32'hDEAD_BEEF);
      load("wrap_0", 32'h0, 3'b000, 32'hDEAD_BEEF);
      load("wrap_1000", 32'h1000, 3'b000, 32'hDEAD_BEEF);

      // Same-cycle read/write: old value before the edge, new after.
      bus.pc = 32'h3024;
      bus.addr = 32'h4;
      bus.wdata = 32'h1111_2222;
      bus.mem_data_type = 3'b000;
      bus.mem_write = 1'b1;
      bus.mem_read = 1'b1;
      #1;
      check_eq("rw_old", bus.rdata, 32'h0);
      step();
      check_eq("rw_new", bus.rdata, 32'h1111_2222);
      idle();

      // Reset wins over a simultaneous store.
      bus.addr = 32'h4;
      bus.wdata = 32'h5555_5555;
      bus.mem_data_type = 3'b000;
      bus.mem_write = 1'b1;
      reset = 1'b0;
      step();
      idle();
      reset = 1'b1;
      load("rst_pri_4", 32'h4, 3'b000, 32'h0);
      load("rst_clr_0", 32'h0, 3'b000, 32'h0);
      check_eq("rst2_flag", {31'd0, bus.align_err}, 32'd0);
      check_eq("rst2_pc", bus.err_pc, 32'h0);
      check_eq("rst2_addr", bus.err_addr, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
